wb_fifo_ctrl: RTL and testbench

- Wishbone-slave controller that sequences and shares one single-clock FIFO instance between two producers: the LM32 bus and a hardware stream port.
- Owns the authoritative occupancy count, full/empty flags, push/pop strobes, flush, sticky error flags and a threshold interrupt.
- Sits between the wishbone interconnect and the FIFO storage.
- The LM32 is the only consumer.

---
 rtl/wb_fifo_pkg.sv | 25 ++
 rtl/wb_fifo_ctrl_if.sv | 14 +
 rtl/wb_fifo_rr_arb.sv | 33 +++
 rtl/wb_fifo_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_wb_fifo_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_fifo_pkg.sv
// Shared constants for the wishbone FIFO controller: register map,
// STATUS/CTRL bit positions and the bus-sequencer state encoding.
package wb_fifo_pkg;

  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_CTRL   = 2'd2;

  localparam int unsigned ST_EMPTY_BIT = 16;
  localparam int unsigned ST_FULL_BIT  = 17;
  localparam int unsigned ST_OVF_BIT   = 18;
  localparam int unsigned ST_UDF_BIT   = 19;

  localparam int unsigned CT_FLUSH_BIT  = 0;
  localparam int unsigned CT_IE_BIT     = 1;
  localparam int unsigned CT_THRESH_LSB = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_CAPT,
    S_ACK
  } state_e;

endpackage

// File: rtl/wb_fifo_ctrl_if.sv
// Wishbone slave bus bundle for wb_fifo_ctrl; names follow the slave view
// (dat_i = write data into the slave, dat_o = read data out of it).
interface wb_fifo_ctrl_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [1:0]  adr;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack;

  modport master (output cyc, stb, we, adr, dat_i, input dat_o, ack);
  modport slave  (input cyc, stb, we, adr, dat_i, output dat_o, ack);
endinterface

// File: rtl/wb_fifo_rr_arb.sv
// Two-requester round-robin arbiter (hw stream vs. wishbone write) for the
// single FIFO push port; full_i masks both requesters.
module wb_fifo_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic req_hw_i,
  input  logic req_wb_i,
  input  logic full_i,
  output logic gnt_hw_o,
  output logic gnt_wb_o
);

  logic hw_prio_q, hw_prio_d;

  always_comb begin
    gnt_hw_o  = 1'b0;
    gnt_wb_o  = 1'b0;
    hw_prio_d = hw_prio_q;
    if (!full_i) begin
      if (req_hw_i && (hw_prio_q || !req_wb_i)) gnt_hw_o = 1'b1;
      else if (req_wb_i)                        gnt_wb_o = 1'b1;
    end
    // priority moves only when someone was actually granted
    if (gnt_hw_o)      hw_prio_d = 1'b0;
    else if (gnt_wb_o) hw_prio_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) hw_prio_q <= 1'b1;
    else     hw_prio_q <= hw_prio_d;
  end

endmodule

// File: rtl/wb_fifo_ctrl.sv
// Wishbone slave that shares one FIFO between the LM32 and a hw stream port;
// owns occupancy, flags, strobes, flush, sticky errors and threshold irq.
module wb_fifo_ctrl
  import wb_fifo_pkg::*;
#(
  parameter int unsigned DATO_WIDTH  = 8,
  parameter int unsigned FIFO_LENGTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_fifo_ctrl_if.slave         wb,
  input  logic                  hw_req,
  input  logic [DATO_WIDTH-1:0] hw_dat,
  output logic                  hw_gnt,
  output logic                  fifo_push,
  output logic [DATO_WIDTH-1:0] fifo_wdata,
  output logic                  fifo_pop,
  input  logic [DATO_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_flush,
  output logic                  irq
);

  localparam int unsigned CW = FIFO_LENGTH + 1;
  localparam logic [CW-1:0] DEPTH = {1'b1, {FIFO_LENGTH{1'b0}}};

  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         thresh_q, thresh_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d, ie_q, ie_d;
  logic [31:0]           dat_o_q, dat_o_d;
  logic                  ack_q, ack_d;
  logic                  hw_gnt_q, hw_gnt_d;
  logic                  push_q, push_d, pop_q, pop_d;
  logic                  flush_q, flush_d, irq_q, irq_d;
  logic [DATO_WIDTH-1:0] wdata_q, wdata_d;

  logic        bus_req, in_idle, full, empty;
  logic        wb_data_wr, flush_now, gnt_hw, gnt_wb;
  logic [31:0] status_w, ctrl_w;
  logic        unused_dat;

  assign unused_dat = ^wb.dat_i;

  assign bus_req    = wb.cyc & wb.stb;
  assign in_idle    = (state_q == S_IDLE);
  assign full       = (count_q == DEPTH);
  assign empty      = (count_q == '0);
  assign wb_data_wr = in_idle & bus_req & wb.we & (wb.adr == ADR_DATA);
  assign flush_now  = in_idle & bus_req & wb.we & (wb.adr == ADR_CTRL) & wb.dat_i[CT_FLUSH_BIT];

  // flush edge masks hw as well, so a coinciding hw beat is refused, not lost
  wb_fifo_rr_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_hw_i (hw_req),
    .req_wb_i (wb_data_wr),
    .full_i   (full | flush_now),
    .gnt_hw_o (gnt_hw),
    .gnt_wb_o (gnt_wb)
  );

  always_comb begin
    status_w                   = '0;
    status_w[CW-1:0]           = count_q;
    status_w[ST_EMPTY_BIT]     = empty;
    status_w[ST_FULL_BIT]      = full;
    status_w[ST_OVF_BIT]       = ovf_q;
    status_w[ST_UDF_BIT]       = udf_q;
    ctrl_w                     = '0;
    ctrl_w[CT_IE_BIT]          = ie_q;
    ctrl_w[CT_THRESH_LSB +: CW] = thresh_q;
  end

  always_comb begin
    state_d  = state_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    ie_d     = ie_q;
    thresh_d = thresh_q;
    dat_o_d  = dat_o_q;
    ack_d    = 1'b0;
    pop_d    = 1'b0;
    flush_d  = flush_now;
    push_d   = gnt_hw | gnt_wb;
    hw_gnt_d = gnt_hw;
    wdata_d  = wdata_q;
    if (gnt_wb)      wdata_d = wb.dat_i[DATO_WIDTH-1:0];
    else if (gnt_hw) wdata_d = hw_dat;
    irq_d    = ie_q & (count_q >= thresh_q);

    case (state_q)
      S_IDLE: begin
        if (bus_req) begin
          case (wb.adr)
            ADR_DATA: begin
              if (wb.we) begin
                if (full) begin
                  ovf_d   = 1'b1;
                  ack_d   = 1'b1;
                  state_d = S_ACK;
                end else if (gnt_wb) begin
                  ack_d   = 1'b1;
                  state_d = S_ACK;
                end
              end else if (empty) begin
                dat_o_d = '0;
                udf_d   = 1'b1;
                ack_d   = 1'b1;
                state_d = S_ACK;
              end else begin
                pop_d   = 1'b1;
                state_d = S_POP;
              end
            end
            ADR_STATUS: begin
              if (wb.we) begin
                if (wb.dat_i[ST_OVF_BIT]) ovf_d = 1'b0;
                if (wb.dat_i[ST_UDF_BIT]) udf_d = 1'b0;
              end else begin
                dat_o_d = status_w;
              end
              ack_d   = 1'b1;
              state_d = S_ACK;
            end
            ADR_CTRL: begin
              if (wb.we) begin
                ie_d     = wb.dat_i[CT_IE_BIT];
                thresh_d = wb.dat_i[CT_THRESH_LSB +: CW];
              end else begin
                dat_o_d = ctrl_w;
              end
              ack_d   = 1'b1;
              state_d = S_ACK;
            end
            default: begin
              if (!wb.we) dat_o_d = '0;
              ack_d   = 1'b1;
              state_d = S_ACK;
            end
          endcase
        end
      end
      S_POP:  state_d = S_CAPT;
      S_CAPT: begin
        dat_o_d = 32'(fifo_rdata);
        ack_d   = 1'b1;
        state_d = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    count_d = count_q;
    if (flush_now)             count_d = '0;
    else if (push_d && !pop_d) count_d = count_q + 1'b1;
    else if (pop_d && !push_d) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      thresh_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      ie_q     <= 1'b0;
      dat_o_q  <= '0;
      ack_q    <= 1'b0;
      hw_gnt_q <= 1'b0;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      flush_q  <= 1'b1;
      irq_q    <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      thresh_q <= thresh_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      ie_q     <= ie_d;
      dat_o_q  <= dat_o_d;
      ack_q    <= ack_d;
      hw_gnt_q <= hw_gnt_d;
      push_q   <= push_d;
      pop_q    <= pop_d;
      flush_q  <= flush_d;
      irq_q    <= irq_d;
      wdata_q  <= wdata_d;
    end
  end

  assign wb.dat_o   = dat_o_q;
  assign wb.ack     = ack_q;
  assign hw_gnt     = hw_gnt_q;
  assign fifo_push  = push_q;
  assign fifo_wdata = wdata_q;
  assign fifo_pop   = pop_q;
  assign fifo_flush = flush_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_wb_fifo_ctrl.sv
// Scoreboard bench for wb_fifo_ctrl (8-bit data, depth 4) with a behavioural
// FIFO store and a hw producer that advances its data on every grant.
module tb_wb_fifo_ctrl;
  import wb_fifo_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned FL = 2;

  typedef struct {
    logic        chk;
    logic [31:0] exp;
    string       name;
  } sb_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          hw_req;
  logic [DW-1:0] hw_dat = 8'hB0;
  logic          hw_gnt, fifo_push, fifo_pop, fifo_flush, irq;
  logic [DW-1:0] fifo_wdata, fifo_rdata;

  int checks = 0;
  int errors = 0;
  int hw_cnt = 0;
  int lat;
  sb_t sb_q[$];

  wb_fifo_ctrl_if bus ();

  wb_fifo_ctrl #(.DATO_WIDTH(DW), .FIFO_LENGTH(FL)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb         (bus),
    .hw_req     (hw_req),
    .hw_dat     (hw_dat),
    .hw_gnt     (hw_gnt),
    .fifo_push  (fifo_push),
    .fifo_wdata (fifo_wdata),
    .fifo_pop   (fifo_pop),
    .fifo_rdata (fifo_rdata),
    .fifo_flush (fifo_flush),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // behavioural FIFO storage driven only by the strobes
  logic [DW-1:0] mem [4];
  logic [1:0]    wr_p = '0, rd_p = '0;
  always @(posedge clk) begin
    if (fifo_flush) begin
      wr_p <= '0;
      rd_p <= '0;
    end else begin
      if (fifo_push) begin
        mem[wr_p] <= fifo_wdata;
        wr_p      <= wr_p + 2'd1;
      end
      if (fifo_pop) begin
        fifo_rdata <= mem[rd_p];
        rd_p       <= rd_p + 2'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (hw_gnt === 1'b1) begin
      hw_cnt = hw_cnt + 1;
      hw_dat = hw_dat + 8'd1;
    end
  end

  // monitor: every ack consumes one scoreboard entry
  always @(negedge clk) begin
    if (bus.ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack=1 dat=%h, required no ack", bus.dat_o);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        if (e.chk) begin
          checks++;
          if (bus.dat_o !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", e.name, bus.dat_o, e.exp);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic xfer(input string name, input logic we, input logic [1:0] adr,
                      input logic [31:0] dat, input logic [31:0] exp, input logic hw_go,
                      output int l);
    sb_q.push_back('{chk: !we, exp: exp, name: name});
    @(posedge clk);
    #1;
    bus.cyc   = 1'b1;
    bus.stb   = 1'b1;
    bus.we    = we;
    bus.adr   = adr;
    bus.dat_i = dat;
    if (hw_go) hw_req = 1'b1;
    l = 0;
    do begin
      @(posedge clk);
      #1;
      l++;
    end while (bus.ack !== 1'b1 && l < 20);
    if (bus.ack !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no ack in %0d cycles, required ack", name, l);
    end
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    bus.we  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    hw_req = 1'b0;
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    bus.we = 1'b0;
    bus.adr = '0;
    bus.dat_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_flush", 32'(fifo_flush), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_dat_o", bus.dat_o, 32'd0);
    check("rst_strobes", {29'd0, hw_gnt, fifo_push, fifo_pop}, 32'd0);
    @(posedge clk);
    #1 check("flush_once", 32'(fifo_flush), 32'd0);
    xfer("st_reset", 1'b0, ADR_STATUS, 0, 32'h0001_0000, 1'b0, lat);
    check("st_lat", lat, 1);

    // basic push/pop ordering and read latency
    xfer("wr_a5", 1'b1, ADR_DATA, 32'hFFFF_FFA5, 0, 1'b0, lat);
    check("wr_lat", lat, 1);
    xfer("wr_3c", 1'b1, ADR_DATA, 32'h0000_003C, 0, 1'b0, lat);
    xfer("rd_a5", 1'b0, ADR_DATA, 0, 32'h0000_00A5, 1'b0, lat);
    check("rd_lat", lat, 3);
    xfer("rd_3c", 1'b0, ADR_DATA, 0, 32'h0000_003C, 1'b0, lat);
    xfer("st_empty", 1'b0, ADR_STATUS, 0, 32'h0001_0000, 1'b0, lat);

    // fill, overflow, W1C
    foreach (sb_q[i]) ;
    for (int unsigned i = 1; i <= 4; i++)
      xfer("wr_fill", 1'b1, ADR_DATA, 32'(i * 8'h11), 0, 1'b0, lat);
    xfer("st_full", 1'b0, ADR_STATUS, 0, 32'h0002_0004, 1'b0, lat);
    xfer("wr_ovf", 1'b1, ADR_DATA, 32'h77, 0, 1'b0, lat);
    check("ovf_lat", lat, 1);
    xfer("st_ovf", 1'b0, ADR_STATUS, 0, 32'h0006_0004, 1'b0, lat);
    xfer("clr_ovf", 1'b1, ADR_STATUS, 32'h0004_0000, 0, 1'b0, lat);
    xfer("st_ovf_clr", 1'b0, ADR_STATUS, 0, 32'h0002_0004, 1'b0, lat);
    for (int unsigned i = 1; i <= 4; i++)
      xfer("rd_drain", 1'b0, ADR_DATA, 0, 32'(i * 8'h11), 1'b0, lat);

    // hw and WB contend: hw wins first, then strict alternation until full
    xfer("wr_c0", 1'b1, ADR_DATA, 32'hC0, 0, 1'b1, lat);
    check("arb_lose_lat", lat, 2);
    xfer("wr_c1", 1'b1, ADR_DATA, 32'hC1, 0, 1'b0, lat);
    check("arb_win_lat", lat, 1);
    repeat (4) @(posedge clk);
    #1 check("hw_grants_full", hw_cnt, 2);
    check("hw_gnt_full", 32'(hw_gnt), 32'd0);
    xfer("st_arb_full", 1'b0, ADR_STATUS, 0, 32'h0002_0004, 1'b0, lat);
    xfer("rd_b0", 1'b0, ADR_DATA, 0, 32'hB0, 1'b0, lat);
    hw_req = 1'b0;
    check("hw_refill", hw_cnt, 3);
    xfer("st_refull", 1'b0, ADR_STATUS, 0, 32'h0002_0004, 1'b0, lat);
    xfer("rd_c0", 1'b0, ADR_DATA, 0, 32'hC0, 1'b0, lat);
    xfer("rd_b1", 1'b0, ADR_DATA, 0, 32'hB1, 1'b0, lat);
    xfer("rd_c1", 1'b0, ADR_DATA, 0, 32'hC1, 1'b0, lat);
    xfer("rd_b2", 1'b0, ADR_DATA, 0, 32'hB2, 1'b0, lat);
    xfer("st_arb_end", 1'b0, ADR_STATUS, 0, 32'h0001_0000, 1'b0, lat);

    // threshold interrupt and flush
    xfer("ctrl_wr", 1'b1, ADR_CTRL, 32'h0000_0302, 0, 1'b0, lat);
    xfer("ctrl_rd", 1'b0, ADR_CTRL, 0, 32'h0000_0302, 1'b0, lat);
    check("irq_below", 32'(irq), 32'd0);
    for (int unsigned i = 0; i < 3; i++)
      xfer("wr_irq", 1'b1, ADR_DATA, 32'(8'hD0 + i), 0, 1'b0, lat);
    check("irq_not_yet", 32'(irq), 32'd0);
    @(posedge clk);
    #1 check("irq_at_thresh", 32'(irq), 32'd1);
    xfer("ctrl_flush", 1'b1, ADR_CTRL, 32'h0000_0303, 0, 1'b0, lat);
    check("flush_pulse", 32'(fifo_flush), 32'd1);
    @(posedge clk);
    #1 check("irq_after_flush", 32'(irq), 32'd0);
    check("flush_single", 32'(fifo_flush), 32'd0);
    xfer("st_flushed", 1'b0, ADR_STATUS, 0, 32'h0001_0000, 1'b0, lat);
    xfer("ctrl_rd_nofl", 1'b0, ADR_CTRL, 0, 32'h0000_0302, 1'b0, lat);
    xfer("ctrl_th0", 1'b1, ADR_CTRL, 32'h0000_0002, 0, 1'b0, lat);
    @(posedge clk);
    #1 check("irq_th0", 32'(irq), 32'd1);
    xfer("ctrl_off", 1'b1, ADR_CTRL, 32'h0, 0, 1'b0, lat);
    @(posedge clk);
    #1 check("irq_off", 32'(irq), 32'd0);
    xfer("rsv_rd", 1'b0, 2'd3, 0, 32'h0, 1'b0, lat);
    check("rsv_lat", lat, 1);

    // underflow, W1C
    xfer("rd_udf", 1'b0, ADR_DATA, 0, 32'h0, 1'b0, lat);
    check("udf_lat", lat, 1);
    xfer("st_udf", 1'b0, ADR_STATUS, 0, 32'h0009_0000, 1'b0, lat);
    xfer("clr_udf", 1'b1, ADR_STATUS, 32'h0008_0000, 0, 1'b0, lat);
    xfer("st_udf_clr", 1'b0, ADR_STATUS, 0, 32'h0001_0000, 1'b0, lat);

    // reset while a pop is in flight
    xfer("wr_5a", 1'b1, ADR_DATA, 32'h5A, 0, 1'b0, lat);
    xfer("st_one", 1'b0, ADR_STATUS, 0, 32'h0000_0001, 1'b0, lat);
    @(posedge clk);
    #1;
    bus.cyc = 1'b1;
    bus.stb = 1'b1;
    bus.we  = 1'b0;
    bus.adr = ADR_DATA;
    @(posedge clk);
    #1 check("pop_strobe", 32'(fifo_pop), 32'd1);
    rst = 1'b1;
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_ack", 32'(bus.ack), 32'd0);
    check("midrst_flush", 32'(fifo_flush), 32'd1);
    check("midrst_dat_o", bus.dat_o, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    xfer("st_midrst", 1'b0, ADR_STATUS, 0, 32'h0001_0000, 1'b0, lat);
    check("midrst_idle_lat", lat, 1);

    repeat (3) @(posedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
